postproc_dec: RTL and testbench

//   Output post-processor placed after the filter datapath. Takes full-precision
//   (DDWIDTH) samples with a valid strobe, decimates by DECIM, rescales by an

---
 rtl/postproc_dec_if.sv | 23 ++
 rtl/postproc_dec.sv | 116 +++++++++++
 tb/tb_postproc_dec.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/postproc_dec_if.sv
// Sample bus between the filter datapath and the post-processor.
// Signal bit order follows the datapath convention: bit 0 is the MSB.
interface postproc_dec_if #(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 32
);
    logic [0:DDWIDTH-1] data_in;
    logic               in_valid;
    logic               phase_clr;
    logic [0:DWIDTH-1]  data_out;
    logic               out_valid;
    logic               sat_flag;

    modport master (
        output data_in, in_valid, phase_clr,
        input  data_out, out_valid, sat_flag
    );

    modport slave (
        input  data_in, in_valid, phase_clr,
        output data_out, out_valid, sat_flag
    );
endinterface

// File: rtl/postproc_dec.sv
// Output post-processor: decimate by DECIM, arithmetic shift by SHIFT, saturate to DWIDTH.
// Build option POSTPROC_ROUND_EN adds round-half-up before the shift; otherwise truncates.
module postproc_dec #(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 32,
    parameter int DECIM   = 3,
    parameter int SHIFT   = 15
) (
    input  logic           clk,
    input  logic           rst,
    postproc_dec_if.slave  bus
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] PH_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] PH_LAST = CW'(DECIM - 1);
    localparam logic [CW-1:0] PH_ONE  = (DECIM > 1) ? CW'(1) : {CW{1'b0}};

    // Clip bounds sign-extended to the widened stage-2 width.
    localparam logic signed [DDWIDTH:0] Y_MAX =
        {{(DDWIDTH-DWIDTH+1){1'b0}}, 1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DDWIDTH:0] Y_MIN =
        {{(DDWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic [CW-1:0]               phase_r;
    logic [CW-1:0]               phase_nxt_s;
    logic                        keep_s;
    logic signed [DDWIDTH-1:0]   s1_data_r;
    logic                        s1_valid_r;
    logic signed [DDWIDTH:0]     ext_s;
    logic signed [DDWIDTH:0]     rnd_s;
    logic signed [DDWIDTH:0]     y_s;
    logic [DWIDTH-1:0]           sat_data_s;
    logic                        sat_hit_s;
    logic [DWIDTH-1:0]           data_out_r;
    logic                        out_valid_r;
    logic                        sat_flag_r;

    // Keep decision and next decimation phase; phase_clr forces the current sample to phase 0.
    always_comb begin
        keep_s      = 1'b0;
        phase_nxt_s = phase_r;
        if (bus.in_valid) begin
            keep_s = (phase_r == PH_ZERO) || bus.phase_clr;
            if (bus.phase_clr) begin
                phase_nxt_s = PH_ONE;
            end else if (phase_r == PH_LAST) begin
                phase_nxt_s = PH_ZERO;
            end else begin
                phase_nxt_s = phase_r + CW'(1);
            end
        end else if (bus.phase_clr) begin
            phase_nxt_s = PH_ZERO;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase counter and stage-1 capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= PH_ZERO;
            s1_data_r  <= {DDWIDTH{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            phase_r    <= phase_nxt_s;
            s1_data_r  <= bus.data_in;
            s1_valid_r <= keep_s;
        end
    end

`ifdef POSTPROC_ROUND_EN
    localparam logic signed [DDWIDTH:0] HALF =
        (SHIFT > 0) ? ((DDWIDTH+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0))
                    : {(DDWIDTH+1){1'b0}};
`endif

    // Rescale in one extra bit so the rounding add cannot wrap, then clip.
    always_comb begin
        ext_s = {s1_data_r[DDWIDTH-1], s1_data_r};
`ifdef POSTPROC_ROUND_EN
        rnd_s = ext_s + HALF;
`else
        rnd_s = ext_s;
`endif
        y_s = rnd_s >>> SHIFT;
        if (y_s > Y_MAX) begin
            sat_data_s = {1'b0, {(DWIDTH-1){1'b1}}};
            sat_hit_s  = 1'b1;
        end else if (y_s < Y_MIN) begin
            sat_data_s = {1'b1, {(DWIDTH-1){1'b0}}};
            sat_hit_s  = 1'b1;
        end else begin
            sat_data_s = y_s[DWIDTH-1:0];
            sat_hit_s  = 1'b0;
        end
    end

    // Output register: data and flag hold between kept samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r  <= {DWIDTH{1'b0}};
            sat_flag_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_out_r <= sat_data_s;
                sat_flag_r <= sat_hit_s;
            end
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sat_flag  = sat_flag_r;
endmodule

// File: tb/tb_postproc_dec.sv
// Self-checking bench for postproc_dec (DWIDTH=16, DDWIDTH=32, DECIM=3, SHIFT=15).
// Follows POSTPROC_ROUND_EN the same way the design does.
module tb_postproc_dec;
    localparam int DW = 16;
    localparam int DDW = 32;
    localparam int DEC = 3;
    localparam int SH = 15;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        s;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   cnt = 0;
    ev_t  pend_q[$];
    logic [15:0] got_q[$];
    logic        exp_v = 1'b0;
    logic [15:0] exp_d = 16'h0000;
    logic        exp_s = 1'b0;

    postproc_dec_if #(.DWIDTH(DW), .DDWIDTH(DDW)) bus ();

    postproc_dec #(.DWIDTH(DW), .DDWIDTH(DDW), .DECIM(DEC), .SHIFT(SH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: floor((x + half) / 2^SH), clipped to the signed DW range.
    task automatic model_out(input logic [31:0] x, output logic [15:0] d, output logic s);
        longint xv;
        longint y;
        longint mx;
        longint mn;
        xv = longint'($signed(x));
`ifdef POSTPROC_ROUND_EN
        if (SH > 0) xv = xv + (longint'(1) << (SH - 1));
`endif
        y  = xv >>> SH;
        mx = (longint'(1) << (DW - 1)) - 1;
        mn = -(longint'(1) << (DW - 1));
        if (y > mx) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (y < mn) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = y[15:0]; s = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic c, input logic r);
        ev_t e;
        bus.in_valid  = v;
        bus.data_in   = d;
        bus.phase_clr = c;
        rst           = r;
        @(posedge clk);
        #1;
        cyc++;
        exp_v = 1'b0;
        if (r) begin
            pend_q.delete();
            cnt   = 0;
            exp_d = 16'h0000;
            exp_s = 1'b0;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                e = pend_q.pop_front();
                exp_v = 1'b1;
                exp_d = e.d;
                exp_s = e.s;
            end
            if (v) begin
                if (cnt == 0 || c) begin
                    e.due = cyc + 1;
                    model_out(d, e.d, e.s);
                    pend_q.push_back(e);
                end
                cnt = c ? (1 % DEC) : ((cnt + 1) % DEC);
            end else if (c) begin
                cnt = 0;
            end
        end
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_v});
        chk("data_out", {16'd0, bus.data_out}, {16'd0, exp_d});
        chk("sat_flag", {31'd0, bus.sat_flag}, {31'd0, exp_s});
        if (bus.out_valid) got_q.push_back(bus.data_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        got_q.delete();
    endtask

    initial begin
        logic [31:0] x;
        bus.in_valid  = 1'b0;
        bus.data_in   = 32'd0;
        bus.phase_clr = 1'b0;

        // Reset state
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("rst_data", {16'd0, bus.data_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        do_reset();

        // Decimation by 3 on a continuous stream
        for (int n = 1; n <= 9; n++) step(1'b1, 32'(n) << 15, 1'b0, 1'b0);
        idle(3);
        chk("dec_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("dec_0", {16'd0, got_q[0]}, 32'd1);
            chk("dec_1", {16'd0, got_q[1]}, 32'd4);
            chk("dec_2", {16'd0, got_q[2]}, 32'd7);
        end

        // Rounding at the half point, both signs
        do_reset();
        step(1'b1, 32'h0000_4000, 1'b0, 1'b0);
        idle(2);
`ifdef POSTPROC_ROUND_EN
        chk("round_pos", {16'd0, bus.data_out}, 32'h0000_0001);
`else
        chk("round_pos", {16'd0, bus.data_out}, 32'h0000_0000);
`endif
        step(1'b1, 32'hFFFF_C000, 1'b1, 1'b0);
        idle(2);
`ifdef POSTPROC_ROUND_EN
        chk("round_neg", {16'd0, bus.data_out}, 32'h0000_0000);
`else
        chk("round_neg", {16'd0, bus.data_out}, 32'h0000_FFFF);
`endif

        // Saturation limits and the largest non-clipping value
        step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        idle(2);
        chk("sat_hi_d", {16'd0, bus.data_out}, 32'h0000_7FFF);
        chk("sat_hi_f", {31'd0, bus.sat_flag}, 32'd1);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        idle(2);
        chk("sat_lo_d", {16'd0, bus.data_out}, 32'h0000_8000);
        chk("sat_lo_f", {31'd0, bus.sat_flag}, 32'd1);
        step(1'b1, 32'h3FFF_8000, 1'b1, 1'b0);
        idle(2);
        chk("nosat_d", {16'd0, bus.data_out}, 32'h0000_7FFF);
        chk("nosat_f", {31'd0, bus.sat_flag}, 32'd0);

        // Resync on the 2nd sample of a burst, then phase_clr alone
        do_reset();
        for (int n = 1; n <= 9; n++) step(1'b1, 32'(n) << 15, (n == 2), 1'b0);
        idle(3);
        chk("resync_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("resync_1", {16'd0, got_q[1]}, 32'd2);
            chk("resync_2", {16'd0, got_q[2]}, 32'd5);
            chk("resync_3", {16'd0, got_q[3]}, 32'd8);
        end
        step(1'b1, 32'd10 << 15, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        got_q.delete();
        step(1'b1, 32'd11 << 15, 1'b0, 1'b0);
        idle(3);
        chk("clr_alone", 32'(got_q.size()), 32'd1);

        // Gapped valid: counter advances only on valid samples
        do_reset();
        for (int i = 0; i < 18; i++) step((i % 2) == 0, 32'(i + 1) << 15, 1'b0, 1'b0);
        idle(3);
        chk("gap_count", 32'(got_q.size()), 32'd3);

        // Reset one cycle after a kept sample drops it
        do_reset();
        step(1'b1, 32'd5 << 15, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, bus.data_out}, 32'd0);
        got_q.delete();
        step(1'b1, 32'd6 << 15, 1'b0, 1'b0);
        idle(3);
        chk("post_rst_keep", 32'(got_q.size()), 32'd1);

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($signed(x) >>> $urandom_range(8, 20));
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
